pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipelined RV32I core. It decides every cycle which pipeline registers advance, hold or take a bubble.
- Resolves load-use hazards that operand forwarding cannot cover, EX-stage redirects (taken branch/jump) and data-memory wait states.
- Supports a debug halt/drain/resume sequence.
- Escalates a stuck memory access to a sticky error.

Parameters:
MEM_TIMEOUT, 255, consecutive dmem stall cycles tolerated before ERROR; 0 disables timeout.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
id_inst_i  in  32  instruction in ID
ex_inst_i  in  32  instruction in EX
ex_redirect_i  in  1  EX resolved taken branch/JAL/JALR, PC target valid
dmem_req_i  in  1  MEM stage has load/store outstanding
dmem_ack_i  in  1  data memory completes access this cycle
halt_req_i  in  1  debug halt request, level
resume_i  in  1  debug resume, pulse
pc_en_o  out  1  PC register load enable
if_id_en_o  out  1  IF/ID enable
if_id_flush_o  out  1  IF/ID load NOP, overrides enable
id_ex_en_o  out  1  ID/EX enable
id_ex_flush_o  out  1  ID/EX load NOP, overrides enable
ex_mem_en_o  out  1  EX/MEM enable
mem_wb_en_o  out  1  MEM/WB enable
mem_wb_flush_o  out  1  MEM/WB load NOP
halted_o  out  1  pipeline drained and frozen
mem_err_o  out  1  sticky dmem timeout
perf_stall_o  out  32  stall-cycle count
perf_flush_o  out  32  redirect count

Behaviour:
- Opcode field is inst[6:2]: LOAD=00000, STORE=01000, BRANCH=11000, OP=01100, LUI=01101, AUIPC=00101, JAL=11011.
- load_use = (ex op==LOAD) && ex rd!=0 && (uses_rs1 && rd==id rs1 || uses_rs2 && rd==id rs2).
  - uses_rs1: all ops except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH only.
- mem_stall = dmem_req_i && !dmem_ack_i.
- States: RUN, DRAIN, HALTED, ERROR. Reset -> RUN, drain_cnt=0, stall_cnt=0, halted_o=0, mem_err_o=0, perf counters 0.
- Outputs are Mealy and combinational from state and inputs. Default in RUN/DRAIN: all enables 1, all flushes 0.
- Per-cycle priority in RUN/DRAIN, highest first:
  1. mem_stall: pc/if_id/id_ex/ex_mem enables 0; mem_wb_flush_o=1. Redirect and load_use are ignored; both re-evaluate when EX moves.
  2. ex_redirect_i: pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1. Redirect wins over load_use because the ID instruction is wrong-path.
  3. load_use: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Exactly one bubble is inserted because the load leaves EX next cycle.
- stall_cnt increments on each mem_stall cycle and clears when mem_stall is low. If MEM_TIMEOUT!=0, mem_stall is high and stall_cnt==MEM_TIMEOUT, the next state is ERROR.
- RUN -> DRAIN: halt_req_i high and not mem_stall. If a redirect occurs in the same cycle, it is still serviced that cycle. drain_cnt clears.
- DRAIN:
  - pc_en_o=ex_redirect_i, so the redirect target is captured for resume.
  - if_id_flush_o=1 every cycle.
  - drain_cnt increments only in cycles with no mem_stall and no load_use.
  - When drain_cnt==3 and advancing, the next state is HALTED. That is 4 advancing cycles, emptying ID/EX/MEM/WB.
  - halt_req_i dropping mid-drain has no effect; the drain completes.
- HALTED: all enables 0, flushes 0, halted_o=1 (registered). On resume_i, the next state is RUN and halted_o goes to 0 in the same edge. halt_req_i is ignored in this state.
- ERROR: all enables 0, mem_err_o=1 (registered). Only reset exits this state.
- Asynchronous reset mid-operation returns all state immediately.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - perf_stall_o increments on every cycle in RUN/DRAIN with mem_stall or load_use.
  - perf_flush_o increments on every serviced redirect.
  - Both saturate at 0xFFFFFFFF.
- Undefined: both ports tied to 0 and no counter flops.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants
  - NOP constant 32'h00000013
  - ctrl_state_e enum {RUN, DRAIN, HALTED, ERROR}
  - helper functions for rs1/rs2/rd field extraction
- Sub-module load_use_detect: combinational, takes id_inst/ex_inst, outputs load_use. Instantiated once.

Test Plan:
- ex_inst=0x0000A283 (lw x5,0(x1)), id_inst=0x00728333 (add x6,x5,x7) -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle.
- Same pair with ex_redirect_i=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1, no hold. With PIPE_CTRL_PERF_EN, perf_flush_o goes 0->1.
- dmem_req=1, ack=0 for 3 cycles then ack=1 -> front enables 0 and mem_wb_flush=1 for 3 cycles; cycle 4 all enables 1.
- MEM_TIMEOUT=4, dmem_req=1 and ack=0 held -> mem_err_o=1 after 5 stall cycles. Enables stay 0 until rst_ni pulse, then state is RUN.
- halt_req pulse with no stalls -> if_id_flush=1 for 4 cycles, then halted_o=1. resume_i pulse -> halted_o=0, enables 1 next cycle.
- halt_req during a 2-cycle dmem stall -> DRAIN is entered after the stall clears; halted_o rises after 4 advancing cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Holds the RV32I opcode constants, the NOP encoding and the controller
// state type. It also provides helpers that pull the opcode and register
// fields out of a 32-bit instruction word.
package pipe_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 5;

  typedef logic [OPC_W-1:0] opc_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  // Opcode field inst[6:2]
  localparam opc_t OPC_LOAD   = 5'b00000;
  localparam opc_t OPC_STORE  = 5'b01000;
  localparam opc_t OPC_BRANCH = 5'b11000;
  localparam opc_t OPC_OP     = 5'b01100;
  localparam opc_t OPC_LUI    = 5'b01101;
  localparam opc_t OPC_AUIPC  = 5'b00101;
  localparam opc_t OPC_JAL    = 5'b11011;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } ctrl_state_e;

  function automatic opc_t get_opc(input logic [XLEN-1:0] inst);
    return inst[6:2];
  endfunction

  function automatic reg_idx_t get_rd(input logic [XLEN-1:0] inst);
    return inst[11:7];
  endfunction

  function automatic reg_idx_t get_rs1(input logic [XLEN-1:0] inst);
    return inst[19:15];
  endfunction

  function automatic reg_idx_t get_rs2(input logic [XLEN-1:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl.
//   master : datapath side, drives hazard/memory/debug inputs
//   slave  : controller side, drives stage enables/flushes and status
interface pipe_ctrl_if;
  import pipe_pkg::*;

  logic [XLEN-1:0] id_inst_i;
  logic [XLEN-1:0] ex_inst_i;
  logic            ex_redirect_i;
  logic            dmem_req_i;
  logic            dmem_ack_i;
  logic            halt_req_i;
  logic            resume_i;

  logic            pc_en_o;
  logic            if_id_en_o;
  logic            if_id_flush_o;
  logic            id_ex_en_o;
  logic            id_ex_flush_o;
  logic            ex_mem_en_o;
  logic            mem_wb_en_o;
  logic            mem_wb_flush_o;
  logic            halted_o;
  logic            mem_err_o;
  logic [31:0]     perf_stall_o;
  logic [31:0]     perf_flush_o;

  modport master (
    output id_inst_i, ex_inst_i, ex_redirect_i, dmem_req_i, dmem_ack_i,
           halt_req_i, resume_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o, halted_o, mem_err_o,
           perf_stall_o, perf_flush_o
  );

  modport slave (
    input  id_inst_i, ex_inst_i, ex_redirect_i, dmem_req_i, dmem_ack_i,
           halt_req_i, resume_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
           ex_mem_en_o, mem_wb_en_o, mem_wb_flush_o, halted_o, mem_err_o,
           perf_stall_o, perf_flush_o
  );
endinterface

// File: rtl/pipe_ctrl_load_use.sv
// load_use_detect: flags a load in EX whose destination register is read
// by the instruction in ID. Forwarding cannot cover this case.
//   i_id_inst  : instruction in ID
//   i_ex_inst  : instruction in EX
//   o_load_use : one-bubble stall required (combinational)
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [XLEN-1:0] i_id_inst,
  input  logic [XLEN-1:0] i_ex_inst,
  output logic            o_load_use
);

  opc_t     w_id_opc;
  reg_idx_t w_ex_rd;
  logic     w_uses_rs1;
  logic     w_uses_rs2;
  logic     w_ex_is_load;
  logic     w_unused;

  assign w_id_opc     = get_opc(i_id_inst);
  assign w_ex_rd      = get_rd(i_ex_inst);
  assign w_ex_is_load = (get_opc(i_ex_inst) == OPC_LOAD);

  // Bits that never take part in hazard detection
  assign w_unused = ^{i_id_inst[31:25], i_id_inst[14:7], i_id_inst[1:0],
                      i_ex_inst[31:12], i_ex_inst[1:0]};

  // U/J formats carry no rs1; only R/S/B formats carry rs2
  assign w_uses_rs1 = (w_id_opc != OPC_LUI) && (w_id_opc != OPC_AUIPC) &&
                      (w_id_opc != OPC_JAL);
  assign w_uses_rs2 = (w_id_opc == OPC_OP) || (w_id_opc == OPC_STORE) ||
                      (w_id_opc == OPC_BRANCH);

  assign o_load_use = w_ex_is_load && (w_ex_rd != '0) &&
                      ((w_uses_rs1 && (w_ex_rd == get_rs1(i_id_inst))) ||
                       (w_uses_rs2 && (w_ex_rd == get_rs2(i_id_inst))));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage RV32I pipeline.
// Each cycle it decides whether each pipeline register advances, holds or
// loads a bubble. It handles load-use hazards, EX redirects, dmem wait
// states, debug halt/drain/resume and a sticky dmem timeout error.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : hazard/memory/debug inputs; stage enables and flushes
//                   (combinational), halted_o/mem_err_o (registered),
//                   perf counters
// Optional: define PIPE_CTRL_PERF_EN to build the saturating stall and
// redirect counters. Without it, perf_stall_o and perf_flush_o read 0.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  pipe_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned DRAIN_W = 2;

  ctrl_state_e          r_state,     w_state_nxt;
  logic [DRAIN_W-1:0]   r_drain_cnt, w_drain_nxt;
  logic [CNT_W-1:0]     r_stall_cnt, w_stall_nxt;
  logic                 r_halted,    w_halted_nxt;
  logic                 r_mem_err,   w_mem_err_nxt;

  logic w_load_use;
  logic w_mem_stall;
  logic w_active;
  logic w_timeout;

  load_use_detect u_load_use (
    .i_id_inst  (bus.id_inst_i),
    .i_ex_inst  (bus.ex_inst_i),
    .o_load_use (w_load_use)
  );

  assign w_mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;
  assign w_active    = (r_state == RUN) || (r_state == DRAIN);
  assign w_timeout   = (MEM_TIMEOUT != 0) && (r_stall_cnt == CNT_W'(MEM_TIMEOUT));

  // State and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_stall_cnt <= '0;
      r_halted    <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_halted    <= w_halted_nxt;
      r_mem_err   <= w_mem_err_nxt;
    end
  end

  // Next state and Mealy stage controls
  always_comb begin
    w_state_nxt        = r_state;
    w_drain_nxt        = r_drain_cnt;
    w_stall_nxt        = '0;
    w_halted_nxt       = r_halted;
    w_mem_err_nxt      = r_mem_err;
    bus.pc_en_o        = 1'b0;
    bus.if_id_en_o     = 1'b0;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_en_o     = 1'b0;
    bus.id_ex_flush_o  = 1'b0;
    bus.ex_mem_en_o    = 1'b0;
    bus.mem_wb_en_o    = 1'b0;
    bus.mem_wb_flush_o = 1'b0;

    unique case (r_state)
      RUN, DRAIN: begin
        bus.pc_en_o     = 1'b1;
        bus.if_id_en_o  = 1'b1;
        bus.id_ex_en_o  = 1'b1;
        bus.ex_mem_en_o = 1'b1;
        bus.mem_wb_en_o = 1'b1;

        if (w_mem_stall) begin
          // Freeze the front while MEM waits; WB receives a bubble
          bus.pc_en_o        = 1'b0;
          bus.if_id_en_o     = 1'b0;
          bus.id_ex_en_o     = 1'b0;
          bus.ex_mem_en_o    = 1'b0;
          bus.mem_wb_flush_o = 1'b1;
          w_stall_nxt        = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
          if (w_timeout) begin
            w_state_nxt   = ERROR;
            w_mem_err_nxt = 1'b1;
          end
        end else if (bus.ex_redirect_i) begin
          // The ID instruction is wrong-path, so any load-use is moot
          bus.if_id_flush_o = 1'b1;
          bus.id_ex_flush_o = 1'b1;
        end else if (w_load_use) begin
          bus.pc_en_o       = 1'b0;
          bus.if_id_en_o    = 1'b0;
          bus.id_ex_flush_o = 1'b1;
        end

        if (r_state == DRAIN) begin
          // Fetch nothing new; only capture a redirect target for resume
          bus.if_id_flush_o = 1'b1;
          bus.pc_en_o       = bus.ex_redirect_i && !w_mem_stall;
          if (!w_mem_stall && !w_load_use) begin
            if (r_drain_cnt == DRAIN_W'(3)) begin
              w_state_nxt  = HALTED;
              w_halted_nxt = 1'b1;
            end else begin
              w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
            end
          end
        end else if (bus.halt_req_i && !w_mem_stall) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = '0;
        end
      end

      HALTED: begin
        if (bus.resume_i) begin
          w_state_nxt  = RUN;
          w_halted_nxt = 1'b0;
        end
      end

      ERROR: begin
      end

      default: begin
      end
    endcase
  end

  assign bus.halted_o  = r_halted;
  assign bus.mem_err_o = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic        w_stall_ev;
  logic        w_flush_ev;

  assign w_stall_ev = w_active && (w_mem_stall || w_load_use);
  assign w_flush_ev = w_active && !w_mem_stall && bus.ex_redirect_i;

  // Saturating performance counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall_ev && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_flush_ev && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall_o = r_perf_stall;
  assign bus.perf_flush_o = r_perf_flush;
`else
  logic w_unused_active;
  assign w_unused_active  = w_active;
  assign bus.perf_stall_o = '0;
  assign bus.perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MEM_TIMEOUT=4): load-use, redirect, dmem
// stall, timeout error with reset recovery, and halt/drain/resume sequences.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  // Stage control vector: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb_en, memwb_fl}
  localparam logic [7:0] V_NORMAL = 8'b1101_0110;
  localparam logic [7:0] V_LDUSE  = 8'b0001_1110;
  localparam logic [7:0] V_REDIR  = 8'b1111_1110;
  localparam logic [7:0] V_MSTALL = 8'b0000_0011;
  localparam logic [7:0] V_DRAIN  = 8'b0111_0110;
  localparam logic [7:0] V_FROZEN = 8'b0000_0000;

  localparam logic [31:0] I_LW_X5   = 32'h0000_A283; // lw  x5,0(x1)
  localparam logic [31:0] I_LW_X0   = 32'h0000_A003; // lw  x0,0(x1)
  localparam logic [31:0] I_ADD_RS1 = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] I_ADD_RS2 = 32'h0053_8333; // add x6,x7,x5
  localparam logic [31:0] I_ADD_X0  = 32'h0070_0333; // add x6,x0,x7
  localparam logic [31:0] I_LUI     = 32'h0002_82B7; // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_ADDI    = 32'h0050_8313; // addi x6,x1,5 (rs2 field = 5)

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if u_if ();

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {u_if.pc_en_o, u_if.if_id_en_o, u_if.if_id_flush_o, u_if.id_ex_en_o,
            u_if.id_ex_flush_o, u_if.ex_mem_en_o, u_if.mem_wb_en_o, u_if.mem_wb_flush_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.id_inst_i     = NOP;
    u_if.ex_inst_i     = NOP;
    u_if.ex_redirect_i = 1'b0;
    u_if.dmem_req_i    = 1'b0;
    u_if.dmem_ack_i    = 1'b0;
    u_if.halt_req_i    = 1'b0;
    u_if.resume_i      = 1'b0;
  endtask

  task automatic hazard(input string tag, input logic [31:0] ex_i, input logic [31:0] id_i,
                        input logic [7:0] exp);
    u_if.ex_inst_i = ex_i;
    u_if.id_inst_i = id_i;
    #1;
    chk(tag, 32'(ctl()), 32'(exp));
    tick();
    idle();
  endtask

  task automatic drain_to_halt(input string tag);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_drain"}, 32'(ctl()), 32'(V_DRAIN));
      chk({tag, "_not_halted"}, 32'(u_if.halted_o), 32'd0);
      tick();
    end
    chk({tag, "_halted"}, 32'(u_if.halted_o), 32'd1);
    chk({tag, "_frozen"}, 32'(ctl()), 32'(V_FROZEN));
  endtask

  initial begin
    idle();
    #12;
    chk("rst_ctl", 32'(ctl()), 32'(V_NORMAL));
    chk("rst_halted", 32'(u_if.halted_o), 32'd0);
    chk("rst_err", 32'(u_if.mem_err_o), 32'd0);
    chk("rst_perf_stall", u_if.perf_stall_o, 32'd0);
    chk("rst_perf_flush", u_if.perf_flush_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use hazard: exactly one bubble, then release once the load leaves EX
    hazard("lu_rs1", I_LW_X5, I_ADD_RS1, V_LDUSE);
    u_if.id_inst_i = I_ADD_RS1;
    #1;
    chk("lu_release", 32'(ctl()), 32'(V_NORMAL));
    tick();
    idle();
    hazard("lu_rs2", I_LW_X5, I_ADD_RS2, V_LDUSE);
    hazard("lu_rd_x0", I_LW_X0, I_ADD_X0, V_NORMAL);
    hazard("lu_lui", I_LW_X5, I_LUI, V_NORMAL);
    hazard("lu_addi", I_LW_X5, I_ADDI, V_NORMAL);

    // Redirect beats load-use
    u_if.ex_redirect_i = 1'b1;
    u_if.ex_inst_i = I_LW_X5;
    u_if.id_inst_i = I_ADD_RS1;
    #1;
    chk("redir_ctl", 32'(ctl()), 32'(V_REDIR));
    chk("redir_perf_pre", u_if.perf_flush_o, 32'd0);
    tick();
`ifdef PIPE_CTRL_PERF_EN
    chk("redir_perf_post", u_if.perf_flush_o, 32'd1);
`else
    chk("redir_perf_off", u_if.perf_flush_o, 32'd0);
`endif
    idle();

    // Three dmem wait cycles; a redirect during the stall is ignored
    for (int i = 0; i < 3; i++) begin
      u_if.dmem_req_i    = 1'b1;
      u_if.dmem_ack_i    = 1'b0;
      u_if.ex_redirect_i = (i == 1);
      #1;
      chk("mstall", 32'(ctl()), 32'(V_MSTALL));
      tick();
    end
    u_if.ex_redirect_i = 1'b0;
    u_if.dmem_ack_i    = 1'b1;
    #1;
    chk("mstall_ack", 32'(ctl()), 32'(V_NORMAL));
    chk("mstall_no_err", 32'(u_if.mem_err_o), 32'd0);
    tick();
    idle();

    // Halt pulse, drain, resume
    u_if.halt_req_i = 1'b1;
    #1;
    chk("halt_req_run", 32'(ctl()), 32'(V_NORMAL));
    tick();
    u_if.halt_req_i = 1'b0;
    drain_to_halt("h1");
    tick();
    u_if.halt_req_i = 1'b1;
    #1;
    chk("halt_ignored", 32'(u_if.halted_o), 32'd1);
    u_if.halt_req_i = 1'b0;
    u_if.resume_i   = 1'b1;
    #1;
    chk("resume_cycle", 32'(ctl()), 32'(V_FROZEN));
    tick();
    u_if.resume_i = 1'b0;
    #1;
    chk("resume_halted", 32'(u_if.halted_o), 32'd0);
    chk("resume_ctl", 32'(ctl()), 32'(V_NORMAL));
    tick();

    // Halt during a two-cycle dmem stall: drain starts after the stall clears
    u_if.halt_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u_if.dmem_req_i = 1'b1;
      #1;
      chk("hstall", 32'(ctl()), 32'(V_MSTALL));
      tick();
    end
    u_if.dmem_req_i = 1'b0;
    #1;
    chk("hstall_clear", 32'(ctl()), 32'(V_NORMAL));
    tick();
    u_if.halt_req_i = 1'b0;
    drain_to_halt("h2");
    u_if.resume_i = 1'b1;
    tick();
    u_if.resume_i = 1'b0;
    #1;
    chk("h2_resume", 32'(ctl()), 32'(V_NORMAL));
    tick();

    // Timeout: fifth consecutive stall cycle escalates to ERROR
    u_if.dmem_req_i = 1'b1;
    u_if.dmem_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_stall", 32'(ctl()), 32'(V_MSTALL));
      chk("to_no_err", 32'(u_if.mem_err_o), 32'd0);
      tick();
    end
    chk("to_err", 32'(u_if.mem_err_o), 32'd1);
    chk("to_frozen", 32'(ctl()), 32'(V_FROZEN));
    idle();
    tick();
    chk("to_sticky", 32'(u_if.mem_err_o), 32'd1);
    chk("to_sticky_ctl", 32'(ctl()), 32'(V_FROZEN));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err", 32'(u_if.mem_err_o), 32'd0);
    chk("arst_ctl", 32'(ctl()), 32'(V_NORMAL));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ctl", 32'(ctl()), 32'(V_NORMAL));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
